puck_pixel_gen: RTL and testbench



---
 rtl/puck_pixel_gen.sv | 213 +++++++++++++++++++++
 tb/tb_puck_pixel_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puck_pixel_gen.sv
// puck_pixel_gen: air-hockey game state and pixel generator for a 640x480 VGA
// pipeline. Consumes the timing generator's pixel tick, video_on and x/y
// counters; owns paddles, puck, scores and the serve/play/scored/over FSM.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   p_tick              one-clk pixel enable from the timing generator
//   video_on            high inside the visible area
//   x, y                current pixel column / row
//   btn_l_up/btn_l_dn   left paddle controls (synchronised, debounced)
//   btn_r_up/btn_r_dn   right paddle controls
//   rgb                 registered {R,G,B} 4:4:4 pixel colour
//   frame_tick          one-clk pulse at the start of vertical blanking
//   score_l, score_r    player scores for the seven-segment block
//   game_over           high once a player reaches the winning score
module puck_pixel_gen #(
  parameter int H_DISP         = 640,
  parameter int V_DISP         = 480,
  parameter int WALL_T         = 8,
  parameter int PUCK_SIZE      = 8,
  parameter int PUCK_SPEED     = 2,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int PADDLE_STEP    = 4,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  output logic [11:0] rgb,
  output logic        frame_tick,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic [9:0] C_H      = 10'(H_DISP);
  localparam logic [9:0] C_V      = 10'(V_DISP);
  localparam logic [9:0] C_WALL   = 10'(WALL_T);
  localparam logic [9:0] C_SIZE   = 10'(PUCK_SIZE);
  localparam logic [9:0] C_SPEED  = 10'(PUCK_SPEED);
  localparam logic [9:0] C_PW     = 10'(PADDLE_W);
  localparam logic [9:0] C_PH     = 10'(PADDLE_H);
  localparam logic [9:0] C_STEP   = 10'(PADDLE_STEP);
  localparam logic [9:0] C_LX     = 10'(LEFT_PADDLE_X);
  localparam logic [9:0] C_RX     = 10'(RIGHT_PADDLE_X);
  localparam logic [9:0] C_PAD_MAX = 10'(V_DISP - WALL_T - PADDLE_H);
  localparam logic [9:0] C_PX0    = 10'((H_DISP - PUCK_SIZE) / 2);
  localparam logic [9:0] C_PY0    = 10'((V_DISP - PUCK_SIZE) / 2);
  localparam logic [9:0] C_PAD0   = 10'((V_DISP - PADDLE_H) / 2);
  localparam logic [7:0] C_SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] C_WIN    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_t;

  state_t      state, state_nx;
  logic [9:0]  px, py, px_nx, py_nx;
  logic        dx, dy, dx_nx, dy_nx;   // 1 = increasing coordinate
  logic [9:0]  lpy, rpy, lpy_nx, rpy_nx;
  logic [3:0]  score_l_nx, score_r_nx;
  logic [7:0]  serve_cnt, serve_cnt_nx;
  logic        left_scored, left_scored_nx;
  logic [11:0] pix;

  // Clamp is checked before the add/subtract so the position never wraps.
  function automatic logic [9:0] paddle_next(input logic [9:0] p,
                                             input logic up,
                                             input logic dn);
    logic [9:0] r;
    r = p;
    if (up && !dn)
      r = (p >= C_WALL + C_STEP) ? p - C_STEP : C_WALL;
    else if (dn && !up)
      r = (p + C_STEP <= C_PAD_MAX) ? p + C_STEP : C_PAD_MAX;
    return r;
  endfunction

  function automatic logic overlap(input logic [9:0] p, input logic [9:0] pad);
    return (p + C_SIZE > pad) && (p < pad + C_PH);
  endfunction

  always_comb begin
    state_nx       = state;
    px_nx          = px;
    py_nx          = py;
    dx_nx          = dx;
    dy_nx          = dy;
    lpy_nx         = lpy;
    rpy_nx         = rpy;
    score_l_nx     = score_l;
    score_r_nx     = score_r;
    serve_cnt_nx   = serve_cnt;
    left_scored_nx = left_scored;

    if (state != OVER) begin
      lpy_nx = paddle_next(lpy, btn_l_up, btn_l_dn);
      rpy_nx = paddle_next(rpy, btn_r_up, btn_r_dn);
    end

    case (state)
      SERVE: begin
        if (serve_cnt == C_SERVE_LAST) begin
          serve_cnt_nx = '0;
          state_nx     = PLAY;
        end else begin
          serve_cnt_nx = serve_cnt + 8'd1;
        end
      end
      PLAY: begin
        if (!dx && px <= C_SPEED) begin
          left_scored_nx = 1'b0;
          state_nx       = SCORED;
        end else if (dx && px + C_SIZE >= C_H - C_SPEED) begin
          left_scored_nx = 1'b1;
          state_nx       = SCORED;
        end else begin
          // Paddle and wall flips are independent, so a corner flips both.
          if (!dx && px >= C_LX && px <= C_LX + C_PW && overlap(py, lpy))
            dx_nx = 1'b1;
          if (dx && px + C_SIZE >= C_RX && px + C_SIZE <= C_RX + C_PW && overlap(py, rpy))
            dx_nx = 1'b0;
          if (!dy && py <= C_WALL + C_SPEED)
            dy_nx = 1'b1;
          if (dy && py + C_SIZE >= C_V - C_WALL - C_SPEED)
            dy_nx = 1'b0;
          px_nx = dx_nx ? px + C_SPEED : px - C_SPEED;
          py_nx = dy_nx ? py + C_SPEED : py - C_SPEED;
        end
      end
      SCORED: begin
        if (left_scored) begin
          score_l_nx = score_l + 4'd1;
          dx_nx      = 1'b1;
        end else begin
          score_r_nx = score_r + 4'd1;
          dx_nx      = 1'b0;
        end
        if (score_l_nx == C_WIN || score_r_nx == C_WIN) begin
          dx_nx    = dx;
          state_nx = OVER;
        end else begin
          px_nx    = C_PX0;
          py_nx    = C_PY0;
          state_nx = SERVE;
        end
      end
      OVER: ;
      default: state_nx = SERVE;
    endcase
  end

  always_comb begin
    pix = '0;
    if (video_on) begin
      if (x >= px && x < px + C_SIZE && y >= py && y < py + C_SIZE)
        pix = 12'h0F0;
      else if (x >= C_LX && x < C_LX + C_PW && y >= lpy && y < lpy + C_PH)
        pix = 12'h00F;
      else if (x >= C_RX && x < C_RX + C_PW && y >= rpy && y < rpy + C_PH)
        pix = 12'hF00;
      else if (y < C_WALL || y >= C_V - C_WALL)
        pix = 12'hFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb         <= '0;
      frame_tick  <= 1'b0;
      state       <= SERVE;
      px          <= C_PX0;
      py          <= C_PY0;
      dx          <= 1'b1;
      dy          <= 1'b1;
      lpy         <= C_PAD0;
      rpy         <= C_PAD0;
      score_l     <= '0;
      score_r     <= '0;
      serve_cnt   <= '0;
      left_scored <= 1'b0;
    end else begin
      frame_tick <= p_tick && (x == '0) && (y == C_V);
      if (p_tick)
        rgb <= pix;
      if (frame_tick) begin
        state       <= state_nx;
        px          <= px_nx;
        py          <= py_nx;
        dx          <= dx_nx;
        dy          <= dy_nx;
        lpy         <= lpy_nx;
        rpy         <= rpy_nx;
        score_l     <= score_l_nx;
        score_r     <= score_r_nx;
        serve_cnt   <= serve_cnt_nx;
        left_scored <= left_scored_nx;
      end
    end
  end

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_puck_pixel_gen.sv
module tb_puck_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [11:0] rgb;
  logic        frame_tick;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  // reference game model
  int m_px, m_py, m_lpy, m_rpy, m_sl, m_sr, m_cnt, m_st; // m_st: 0 serve,1 play,2 scored,3 over
  bit m_dx, m_dy, m_left_scored;
  int m_lhits;

  always #5 clk = ~clk;

  puck_pixel_gen #(
    .H_DISP(640), .V_DISP(480), .WALL_T(8), .PUCK_SIZE(8), .PUCK_SPEED(2),
    .PADDLE_W(8), .PADDLE_H(64), .PADDLE_STEP(4), .LEFT_PADDLE_X(16),
    .RIGHT_PADDLE_X(616), .SERVE_FRAMES(60), .WIN_SCORE(9)
  ) u_dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn),
    .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn), .rgb(rgb),
    .frame_tick(frame_tick), .score_l(score_l), .score_r(score_r),
    .game_over(game_over)
  );

  task automatic model_reset();
    m_px = 316; m_py = 236; m_dx = 1; m_dy = 1;
    m_lpy = 208; m_rpy = 208; m_sl = 0; m_sr = 0;
    m_cnt = 0; m_st = 0; m_left_scored = 0;
  endtask

  task automatic model_frame(input bit lu, input bit ld, input bit ru, input bit rd);
    int lp, rp;
    bit ndx, ndy;
    lp = m_lpy; rp = m_rpy;
    if (m_st != 3) begin
      if (lu && !ld) lp = (m_lpy - 4 < 8) ? 8 : m_lpy - 4;
      if (ld && !lu) lp = (m_lpy + 4 > 408) ? 408 : m_lpy + 4;
      if (ru && !rd) rp = (m_rpy - 4 < 8) ? 8 : m_rpy - 4;
      if (rd && !ru) rp = (m_rpy + 4 > 408) ? 408 : m_rpy + 4;
    end
    case (m_st)
      0: begin
        if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
        else m_cnt++;
      end
      1: begin
        ndx = m_dx; ndy = m_dy;
        if (!m_dx && m_px <= 2) begin
          m_left_scored = 0; m_st = 2;
        end else if (m_dx && m_px + 8 >= 638) begin
          m_left_scored = 1; m_st = 2;
        end else begin
          if (!m_dx && m_px >= 16 && m_px <= 24 && m_py + 8 > m_lpy && m_py < m_lpy + 64) begin
            ndx = 1; m_lhits++;
          end
          if (m_dx && m_px + 8 >= 616 && m_px + 8 <= 624 && m_py + 8 > m_rpy && m_py < m_rpy + 64)
            ndx = 0;
          if (!m_dy && m_py <= 10) ndy = 1;
          if (m_dy && m_py + 8 >= 470) ndy = 0;
          m_dx = ndx; m_dy = ndy;
          m_px = m_px + (ndx ? 2 : -2);
          m_py = m_py + (ndy ? 2 : -2);
        end
      end
      2: begin
        if (m_left_scored) m_sl++; else m_sr++;
        if (m_sl == 9 || m_sr == 9) m_st = 3;
        else begin
          m_px = 316; m_py = 236; m_dx = m_left_scored; m_st = 0;
        end
      end
      default: ;
    endcase
    m_lpy = lp; m_rpy = rp;
  endtask

  function automatic logic [11:0] exp_pix(input int xx, input int yy);
    if (xx >= m_px && xx < m_px + 8 && yy >= m_py && yy < m_py + 8) return 12'h0F0;
    if (xx >= 16 && xx < 24 && yy >= m_lpy && yy < m_lpy + 64) return 12'h00F;
    if (xx >= 616 && xx < 624 && yy >= m_rpy && yy < m_rpy + 64) return 12'hF00;
    if (yy < 8 || yy >= 472) return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic probe(input int xx, input int yy, input bit von);
    logic [11:0] e;
    @(negedge clk);
    p_tick = 1'b1; video_on = von; x = 10'(xx); y = 10'(yy);
    exp_q.push_back(von ? exp_pix(xx, yy) : 12'h000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (rgb !== e) begin
      n_fail++;
      $display("FAIL pixel(%0d,%0d) von=%0b rgb=%h expected %h", xx, yy, von, rgb, e);
    end
  endtask

  task automatic probe_set();
    probe(m_px, m_py, 1);
    probe(m_px + 7, m_py + 7, 1);
    probe(m_px - 1, m_py, 1);
    probe(m_px + 8, m_py + 7, 1);
    probe(m_px, m_py - 1, 1);
    probe(m_px + 7, m_py + 8, 1);
    probe(20, m_lpy, 1);
    probe(20, m_lpy - 1, 1);
    probe(20, m_lpy + 63, 1);
    probe(20, m_lpy + 64, 1);
    probe(620, m_rpy, 1);
    probe(620, m_rpy - 1, 1);
    probe(620, m_rpy + 63, 1);
    probe(620, m_rpy + 64, 1);
    @(negedge clk);
    p_tick = 1'b0;
  endtask

  task automatic check_status(input string tag);
    n_checks++;
    if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr) || game_over !== (m_st == 3)) begin
      n_fail++;
      $display("FAIL %s score_l=%0d score_r=%0d game_over=%0b expected %0d %0d %0b",
               tag, score_l, score_r, game_over, m_sl, m_sr, m_st == 3);
    end
  endtask

  task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit probes);
    @(negedge clk);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    p_tick = 1'b1; video_on = 1'b0; x = 10'd0; y = 10'd480;
    @(posedge clk); #1;
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL frame_tick_rise got=%b expected 1", frame_tick);
    end
    @(negedge clk);
    p_tick = 1'b0; x = 10'd1;
    @(posedge clk); #1;
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL frame_tick_fall got=%b expected 0", frame_tick);
    end
    model_frame(lu, ld, ru, rd);
    check_status("frame_status");
    if (probes) probe_set();
  endtask

  task automatic test_reset();
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rgb !== 12'h000 || frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_out rgb=%h frame_tick=%b expected 000 0", rgb, frame_tick);
    end
    check_status("reset_status");
    @(negedge clk);
    reset = 1'b0;
    probe_set();
    probe(316, 236, 0);
    probe(100, 5, 1);
    probe(5, 5, 1);
    probe(300, 475, 1);
    probe(5, 100, 1);
    probe(316, 236, 1);
    @(negedge clk);
    p_tick = 1'b0; x = 10'd0; y = 10'd0;
    @(posedge clk); #1;
    n_checks++;
    if (rgb !== 12'h0F0) begin
      n_fail++; $display("FAIL rgb_hold got=%h expected 0f0", rgb);
    end
    do_frame(0, 0, 0, 0, 1);
  endtask

  task automatic test_paddles();
    repeat (60) do_frame(1, 0, 0, 1, 1);
    repeat (5) do_frame(1, 1, 1, 1, 1);
  endtask

  task automatic test_reset_mid_frame();
    probe(m_px, m_py, 1);
    @(negedge clk);
    p_tick = 1'b1; video_on = 1'b0; x = 10'd0; y = 10'd480;
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (rgb !== 12'h000 || frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL async_reset rgb=%h frame_tick=%b expected 000 0", rgb, frame_tick);
    end
    check_status("mid_reset_status");
    @(posedge clk); #1;
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL ft_in_reset got=%b expected 0", frame_tick);
    end
    @(negedge clk);
    reset = 1'b0; p_tick = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL ft_after_reset got=%b expected 0", frame_tick);
    end
    probe_set();
  endtask

  task automatic test_rally();
    int budget;
    repeat (38) do_frame(0, 0, 0, 1, 1);
    m_lhits = 0;
    budget = 800;
    while (m_lhits == 0 && budget > 0) begin
      do_frame(0, 0, 0, 0, 1);
      budget--;
    end
    if (m_lhits == 0) begin
      n_fail++; $display("FAIL rally_left_hit hits=%0d expected >0", m_lhits);
    end
    repeat (4) do_frame(0, 0, 0, 0, 1);
  endtask

  task automatic test_play_to_over();
    int budget, k;
    budget = 8000;
    k = 0;
    while (m_st != 3 && budget > 0) begin
      do_frame(0, 0, 1, 0, (k % 4) == 0);
      k++;
      budget--;
    end
    if (m_st != 3) begin
      n_fail++; $display("FAIL game_over_timeout game_over=%b expected 1", game_over);
    end
    probe_set();
    repeat (4) do_frame(1, 0, 0, 1, 1);
    check_status("over_hold");
  endtask

  initial begin
    test_reset();
    test_paddles();
    test_reset_mid_frame();
    test_rally();
    test_play_to_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
